// File: rtl/int_ctrl.sv
// Maskable, edge-triggered priority interrupt controller.
// Latches rising edges on the irq lines, dispatches the lowest-index enabled
// pending line while the CPU is in user mode, and holds the vector until the
// CPU enters system mode.
// Optional feature macro: INT_LOST_CNT_EN adds a saturating count of edges
// absorbed by an already-pending line (ports lost_clr / lost_cnt).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no request outstanding, waiting for an enabled pending line
// REQ     | manager_irq high, vector presented, waiting for system mode
// SERVICE | CPU in system mode handling cur_ch, waiting for user mode
module int_ctrl #(
    parameter int                N_IRQ      = 6,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 'h10,
    parameter int                VEC_STRIDE = 4,
    parameter logic [N_IRQ-1:0]  EN_RESET   = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              irq_en_we,
    input  logic [N_IRQ-1:0]  irq_en_wdata,
    output logic [N_IRQ-1:0]  irq_en,
    output logic [N_IRQ-1:0]  ack,
    input  logic              priv_lv,
    output logic              manager_irq,
    output logic [ADDR_W-1:0] int_addr,
    output logic [3:0]        cur_ch
`ifdef INT_LOST_CNT_EN
    ,
    input  logic              lost_clr,
    output logic [7:0]        lost_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state_q, state_d;
    logic [N_IRQ-1:0]   irq_q;
    logic [N_IRQ-1:0]   pending;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   cand;
    logic [N_IRQ-1:0]   win_oh;
    logic [N_IRQ-1:0]   cur_oh;
    logic [N_IRQ-1:0]   pend_clr;
    logic [N_IRQ-1:0]   ack_set;
    logic [3:0]         win_idx;
    logic               win_found;
    logic               take;
    logic               serve;

    // Edge detect and the set of lines eligible for dispatch.
    always_comb begin
        rise = irq & ~irq_q;
        cand = pending & irq_en;
    end

    // Lowest-index eligible line wins; scanning downward leaves the smallest index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_found = 1'b1;
                win_idx   = 4'(i);
            end
        end
        for (int i = 0; i < N_IRQ; i++) begin
            win_oh[i] = win_found && (win_idx == 4'(i));
        end
    end

    // One-hot of the line currently in flight, avoids indexing with a 4-bit channel.
    always_comb begin
        cur_oh = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            cur_oh[i] = (cur_ch == 4'(i));
        end
    end

    // FSM next-state plus the take/serve strobes that drive the datapath.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        serve   = 1'b0;
        case (state_q)
            IDLE: begin
                if (priv_lv && win_found) begin
                    state_d = REQ;
                    take    = 1'b1;
                end
            end
            REQ: begin
                if (!priv_lv) begin
                    state_d = SERVICE;
                    serve   = 1'b1;
                end
            end
            SERVICE: begin
                if (priv_lv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The winner's pending bit is cleared before the edge capture is merged
    // back in, so an edge arriving on the taken line re-arms it.
    always_comb begin
        pend_clr = take  ? win_oh : '0;
        ack_set  = serve ? (cur_oh & ~pending) : '0;
    end

    assign manager_irq = (state_q == REQ);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Edge history, pending/ack bookkeeping, enable mask and vector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q    <= '0;
            pending  <= '0;
            ack      <= '1;
            irq_en   <= EN_RESET;
            int_addr <= '0;
            cur_ch   <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~pend_clr) | rise;
            ack     <= (ack | ack_set) & ~rise;
            if (irq_en_we) irq_en <= irq_en_wdata;
            if (take) begin
                cur_ch   <= win_idx;
                int_addr <= VEC_BASE + ADDR_W'(int'(win_idx) * VEC_STRIDE);
            end
        end
    end

`ifdef INT_LOST_CNT_EN
    logic [N_IRQ-1:0] lost_hits;
    logic [4:0]       lost_inc;
    logic [8:0]       lost_sum;

    // Edges landing on a line that is still pending (and not being taken this edge).
    always_comb begin
        lost_hits = rise & pending & ~pend_clr;
        lost_inc  = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            lost_inc = lost_inc + 5'(lost_hits[i]);
        end
        lost_sum = 9'(lost_cnt) + 9'(lost_inc);
    end

    // Saturating lost-edge counter; clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  lost_cnt <= '0;
        else if (lost_clr)           lost_cnt <= '0;
        else if (lost_sum > 9'd255)  lost_cnt <= 8'hFF;
        else                         lost_cnt <= lost_sum[7:0];
    end
`endif

endmodule
